// File: rtl/player_motion_ctl.sv
// player_motion_ctl: frame-stepped player FSM (idle/walk/jump) with saturating x and gravity-driven y.
// Optional horizontal acceleration enabled by defining PLAYER_MOTION_ACCEL_EN.
module player_motion_ctl #(
  parameter int W        = 12,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 1023,
  parameter int X_START  = 0,
  parameter int Y_MIN    = 0,
  parameter int Y_GROUND = 600,
  parameter int STEP     = 2,
  parameter int JUMP_V   = 8,
  parameter int GRAV     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         v_tick,
  input  logic         m_left,
  input  logic         m_right,
  input  logic         m_jump,
  output logic [W-1:0] xpos_player,
  output logic [W-1:0] ypos_player,
  output logic         in_air,
  output logic         facing_left
);
  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, JUMP} state_t;
  localparam logic signed [W:0] XLO  = (W+1)'(X_MIN);
  localparam logic signed [W:0] XHI  = (W+1)'(X_MAX);
  localparam logic signed [W:0] YLO  = (W+1)'(Y_MIN);
  localparam logic signed [W:0] YGND = (W+1)'(Y_GROUND);
  state_t              state;
  state_t              walk;
  logic                v_tick_q;
  logic                frame;
  logic                go_l;
  logic                go_r;
  logic                one;
  logic signed [W-1:0] vy;
  logic        [W-1:0] step;
  logic signed [W:0]   x_calc;
  logic        [W-1:0] x_n;
  logic signed [W:0]   y_calc;
  assign frame = v_tick & ~v_tick_q;
  assign go_l  = m_left & ~m_right;
  assign go_r  = m_right & ~m_left;
  assign one   = go_l | go_r;
  assign walk  = go_r ? RIGHT : go_l ? LEFT : IDLE;
`ifdef PLAYER_MOTION_ACCEL_EN
  logic [W-1:0] vx;
  logic [W-1:0] vx_base;
  logic [W-1:0] vx_n;
  // speed carries over only while the same single direction stays held
  assign vx_base = (one && (go_l == facing_left)) ? vx : '0;
  assign vx_n    = !one ? '0 : (vx_base >= W'(STEP)) ? W'(STEP) : vx_base + 1'b1;
  assign step    = vx_n;
  always_ff @(posedge clk) begin
    if (!rst_n) vx <= '0;
    else if (frame) vx <= vx_n;
  end
`else
  assign step = W'(STEP);
`endif
  assign x_calc = go_r ? $signed({1'b0, xpos_player}) + $signed({1'b0, step})
                : go_l ? $signed({1'b0, xpos_player}) - $signed({1'b0, step})
                : $signed({1'b0, xpos_player});
  assign x_n    = (x_calc < XLO) ? W'(X_MIN) : (x_calc > XHI) ? W'(X_MAX) : x_calc[W-1:0];
  assign y_calc = $signed({1'b0, ypos_player}) - $signed({vy[W-1], vy});
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_air      <= 1'b0;
      xpos_player <= W'(X_START);
      ypos_player <= W'(Y_GROUND);
      vy          <= '0;
      facing_left <= 1'b0;
      v_tick_q    <= 1'b0;
    end else begin
      v_tick_q <= v_tick;
      if (frame) begin
        xpos_player <= x_n;
        if (one) facing_left <= go_l;
        if (state == JUMP) begin
          vy <= vy - $signed(W'(GRAV));
          if (y_calc < YLO) begin
            ypos_player <= W'(Y_MIN);
            vy          <= '0;
          end else if (y_calc >= YGND) begin
            ypos_player <= W'(Y_GROUND);
            vy          <= '0;
            state       <= walk;
            in_air      <= 1'b0;
          end else begin
            ypos_player <= y_calc[W-1:0];
          end
        end else if (m_jump) begin
          state  <= JUMP;
          in_air <= 1'b1;
          vy     <= W'(JUMP_V);
        end else begin
          state <= walk;
        end
      end
    end
  end
endmodule

// File: tb/tb_player_motion_ctl.sv
// tb_player_motion_ctl: directed checks of walking, saturation, jump arc, tick edge detection and reset.
module tb_player_motion_ctl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v_tick = 1'b0;
  logic        m_left = 1'b0;
  logic        m_right = 1'b0;
  logic        m_jump = 1'b0;
  logic [11:0] xpos_player;
  logic [11:0] ypos_player;
  logic        in_air;
  logic        facing_left;
  int          errors = 0;
  int          checks = 0;
  int          arc [17] = '{592, 585, 579, 574, 570, 567, 565, 564, 564, 565, 567, 570, 574, 579, 585, 592, 600};
  player_motion_ctl dut (
    .clk(clk), .rst_n(rst_n), .v_tick(v_tick), .m_left(m_left), .m_right(m_right),
    .m_jump(m_jump), .xpos_player(xpos_player), .ypos_player(ypos_player),
    .in_air(in_air), .facing_left(facing_left)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic frame();
    @(negedge clk) v_tick = 1'b1;
    @(negedge clk) v_tick = 1'b0;
    @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_x", int'(xpos_player), 0);
    chk("rst_y", int'(ypos_player), 600);
    chk("rst_air", int'(in_air), 0);
    chk("rst_face", int'(facing_left), 0);
    m_right = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      frame();
      chk($sformatf("walk_r%0d", i), int'(xpos_player), 2 * i);
    end
    chk("walk_face", int'(facing_left), 0);
    m_right = 1'b0;
    m_left = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      frame();
      chk($sformatf("walk_l%0d", i), int'(xpos_player), (6 - 2 * i < 0) ? 0 : 6 - 2 * i);
    end
    chk("left_face", int'(facing_left), 1);
    m_left = 1'b0;
    m_right = 1'b1;
    repeat (511) frame();
    chk("near_max", int'(xpos_player), 1022);
    frame();
    chk("sat_max", int'(xpos_player), 1023);
    frame();
    chk("hold_max", int'(xpos_player), 1023);
    m_right = 1'b0;
    do_reset();
    m_jump = 1'b1;
    frame();
    m_jump = 1'b0;
    chk("jump_air", int'(in_air), 1);
    chk("jump_y0", int'(ypos_player), 600);
    for (int f = 1; f <= 17; f++) begin
      m_right = (f == 3);
      m_jump = (f == 5 || f == 6 || f >= 10);
      frame();
      chk($sformatf("arc_y%0d", f), int'(ypos_player), arc[f-1]);
      chk($sformatf("arc_air%0d", f), int'(in_air), (f < 17) ? 1 : 0);
    end
    m_right = 1'b0;
    chk("air_x", int'(xpos_player), 2);
    frame();
    m_jump = 1'b0;
    chk("rejump_air", int'(in_air), 1);
    chk("rejump_y", int'(ypos_player), 600);
    for (int f = 1; f <= 3; f++) frame();
    chk("mid_y", int'(ypos_player), 579);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    chk("abort_y", int'(ypos_player), 600);
    chk("abort_x", int'(xpos_player), 0);
    chk("abort_air", int'(in_air), 0);
    v_tick = 1'b1;
    m_right = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("tick_at_rst", int'(xpos_player), 2);
    repeat (100) @(negedge clk);
    chk("tick_held", int'(xpos_player), 2);
    v_tick = 1'b0;
    m_left = 1'b1;
    frame();
    chk("both_x", int'(xpos_player), 2);
    chk("both_face", int'(facing_left), 0);
    m_right = 1'b0;
    frame();
    chk("left_x", int'(xpos_player), 0);
    chk("left_face2", int'(facing_left), 1);
    m_right = 1'b1;
    frame();
    chk("both_hold_face", int'(facing_left), 1);
    m_left = 1'b0;
    m_right = 1'b0;
    frame();
    chk("none_hold_face", int'(facing_left), 1);
    chk("none_x", int'(xpos_player), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
